// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle KGPRisc control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// variable-latency memory handshakes, branch evaluation, retire counting and traps.
module multicycle_ctrl_fsm #(
    parameter int OPW     = 6,
    parameter int ALUW    = 3,
    parameter int MEM_TMO = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPW-1:0]   opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             flag_z,
    input  logic             flag_c,
    input  logic             flag_s,
    input  logic             flag_v,
    output logic             imem_req,
    output logic             ir_write,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [ALUW-1:0]  alu_op,
    output logic             alu_src,
    output logic             flags_we,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             push_ret,
    output logic             busy,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    localparam int TW = $clog2(MEM_TMO + 1);
    localparam logic [TW-1:0] TMO = TW'(MEM_TMO);

    // Opcode map: ALU ops, immediate/shift-amount forms, memory ops, then all branches from 0x14 up
    localparam logic [OPW-1:0] OP_ADD   = OPW'(6'h00);
    localparam logic [OPW-1:0] OP_COMP  = OPW'(6'h01);
    localparam logic [OPW-1:0] OP_AND   = OPW'(6'h02);
    localparam logic [OPW-1:0] OP_XOR   = OPW'(6'h03);
    localparam logic [OPW-1:0] OP_SHLL  = OPW'(6'h04);
    localparam logic [OPW-1:0] OP_SHRL  = OPW'(6'h05);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'h08);
    localparam logic [OPW-1:0] OP_COMPI = OPW'(6'h09);
    localparam logic [OPW-1:0] OP_SHLLV = OPW'(6'h0C);
    localparam logic [OPW-1:0] OP_SHRLV = OPW'(6'h0D);
    localparam logic [OPW-1:0] OP_SHRA  = OPW'(6'h0E);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'h10);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'h11);
    localparam logic [OPW-1:0] OP_SHRAV = OPW'(6'h12);
    localparam logic [OPW-1:0] OP_B     = OPW'(6'h14);
    localparam logic [OPW-1:0] OP_BR    = OPW'(6'h15);
    localparam logic [OPW-1:0] OP_BZ    = OPW'(6'h16);
    localparam logic [OPW-1:0] OP_BNZ   = OPW'(6'h17);
    localparam logic [OPW-1:0] OP_BCY   = OPW'(6'h18);
    localparam logic [OPW-1:0] OP_BNCY  = OPW'(6'h19);
    localparam logic [OPW-1:0] OP_BS    = OPW'(6'h1A);
    localparam logic [OPW-1:0] OP_BNS   = OPW'(6'h1B);
    localparam logic [OPW-1:0] OP_BV    = OPW'(6'h1C);
    localparam logic [OPW-1:0] OP_BNV   = OPW'(6'h1D);
    localparam logic [OPW-1:0] OP_CALL  = OPW'(6'h1E);
    localparam logic [OPW-1:0] OP_RET   = OPW'(6'h1F);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t           state, state_next;
    logic [OPW-1:0]   op_q;
    logic [TW-1:0]    wait_cnt;
    logic [1:0]       cause_q;
    logic [CNT_W-1:0] ret_q;
    logic             retire;
    logic             is_lw, is_sw, is_br, timed_out;

    function automatic logic op_legal(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_COMP, OP_AND, OP_XOR, OP_SHLL, OP_SHRL, OP_ADDI, OP_COMPI,
            OP_SHLLV, OP_SHRLV, OP_SHRA, OP_LW, OP_SW, OP_SHRAV,
            OP_B, OP_BR, OP_BZ, OP_BNZ, OP_BCY, OP_BNCY, OP_BS, OP_BNS,
            OP_BV, OP_BNV, OP_CALL, OP_RET: op_legal = 1'b1;
            default:                        op_legal = 1'b0;
        endcase
    endfunction

    assign is_lw      = (op_q == OP_LW);
    assign is_sw      = (op_q == OP_SW);
    assign is_br      = (op_q >= OP_B);
    assign timed_out  = (wait_cnt == TMO);
    assign trap_cause = cause_q;
    assign retired    = ret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            wait_cnt <= '0;
            cause_q  <= '0;
            ret_q    <= '0;
        end else begin
            if (state == S_DECODE) op_q <= opcode;
            // Staying in FETCH/MEM implies ready is low and the limit is not yet reached
            if (state_next != state)
                wait_cnt <= '0;
            else if (state == S_FETCH || state == S_MEM)
                wait_cnt <= wait_cnt + TW'(1);
            if (state_next == S_TRAP && state != S_TRAP)
                cause_q <= (state == S_DECODE) ? 2'b01 : (state == S_FETCH) ? 2'b10 : 2'b11;
            if (retire) ret_q <= ret_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  if (imem_ready) state_next = S_DECODE;
                      else if (timed_out) state_next = S_TRAP;
            S_DECODE: state_next = op_legal(opcode) ? S_EXEC : S_TRAP;
            S_EXEC:   if (is_br) state_next = S_FETCH;
                      else if (is_lw || is_sw) state_next = S_MEM;
                      else state_next = S_WB;
            S_MEM:    if (dmem_ready) state_next = is_lw ? S_WB : S_FETCH;
                      else if (timed_out) state_next = S_TRAP;
            S_WB:     state_next = S_FETCH;
            default:  state_next = S_TRAP;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        alu_op     = '0;
        alu_src    = 1'b0;
        flags_we   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        push_ret   = 1'b0;
        retire     = 1'b0;
        busy       = (state != S_IDLE) && (state != S_TRAP);
        trap       = (state == S_TRAP);
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADDI, OP_LW, OP_SW: begin alu_op = ALUW'(0); alu_src = 1'b1; end
                    OP_COMP:               alu_op = ALUW'(1);
                    OP_COMPI:              begin alu_op = ALUW'(1); alu_src = 1'b1; end
                    OP_AND:                alu_op = ALUW'(2);
                    OP_XOR:                alu_op = ALUW'(3);
                    OP_SHLL:               begin alu_op = ALUW'(4); alu_src = 1'b1; end
                    OP_SHLLV:              alu_op = ALUW'(4);
                    OP_SHRL:               begin alu_op = ALUW'(5); alu_src = 1'b1; end
                    OP_SHRLV:              alu_op = ALUW'(5);
                    OP_SHRA:               begin alu_op = ALUW'(6); alu_src = 1'b1; end
                    OP_SHRAV:              alu_op = ALUW'(6);
                    default:               ;
                endcase
                flags_we = !is_br && !is_lw && !is_sw;
                if (is_br) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    case (op_q)
                        OP_B:    pc_src = 2'd1;
                        OP_BR:   pc_src = 2'd2;
                        OP_RET:  pc_src = 2'd3;
                        OP_CALL: begin pc_src = 2'd1; push_ret = 1'b1; end
                        OP_BZ:   pc_src = {1'b0, flag_z};
                        OP_BNZ:  pc_src = {1'b0, !flag_z};
                        OP_BCY:  pc_src = {1'b0, flag_c};
                        OP_BNCY: pc_src = {1'b0, !flag_c};
                        OP_BS:   pc_src = {1'b0, flag_s};
                        OP_BNS:  pc_src = {1'b0, !flag_s};
                        OP_BV:   pc_src = {1'b0, flag_v};
                        OP_BNV:  pc_src = {1'b0, !flag_v};
                        default: pc_src = 2'd0;
                    endcase
                end
            end
            S_MEM: begin
                dmem_read  = is_lw;
                dmem_write = is_sw;
                if (is_sw && dmem_ready) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_lw;
                pc_write   = 1'b1;
                retire     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench: per-instruction cycle traces built from the phase/latency rules,
// applied as {inputs, expected outputs} vectors, plus reset/trap corner sequences.
module tb_multicycle_ctrl_fsm;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = '0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0;
    logic        flag_z = 1'b0, flag_c = 1'b0, flag_s = 1'b0, flag_v = 1'b0;
    logic        imem_req, ir_write, dmem_read, dmem_write;
    logic [2:0]  alu_op;
    logic        alu_src, flags_we, reg_write, mem_to_reg, pc_write;
    logic [1:0]  pc_src;
    logic        push_ret, busy, trap;
    logic [1:0]  trap_cause;
    logic [31:0] retired;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.OPW(6), .ALUW(3), .MEM_TMO(TMO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s), .flag_v(flag_v),
        .imem_req(imem_req), .ir_write(ir_write), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .alu_op(alu_op), .alu_src(alu_src), .flags_we(flags_we), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .pc_write(pc_write), .pc_src(pc_src), .push_ret(push_ret),
        .busy(busy), .trap(trap), .trap_cause(trap_cause), .retired(retired)
    );

    typedef struct packed {
        logic        imem_req, ir_write, dmem_read, dmem_write;
        logic [2:0]  alu_op;
        logic        alu_src, flags_we, reg_write, mem_to_reg, pc_write;
        logic [1:0]  pc_src;
        logic        push_ret, busy, trap;
        logic [1:0]  trap_cause;
        logic [31:0] retired;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic       ir;
        logic       dr;
        logic [3:0] fl;
        byte        ph;
        out_t       exp;
    } vec_t;

    vec_t        vq[$];
    out_t        act;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] ret_cnt = '0;

    assign act = {imem_req, ir_write, dmem_read, dmem_write, alu_op, alu_src, flags_we, reg_write,
                  mem_to_reg, pc_write, pc_src, push_ret, busy, trap, trap_cause, retired};

    task automatic check(input string name, input out_t a, input out_t e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, a, e);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return (op <= 6'h05) || (op == 6'h08) || (op == 6'h09) || (op >= 6'h0C && op <= 6'h0E) ||
               (op >= 6'h10 && op <= 6'h12) || (op >= 6'h14 && op <= 6'h1F);
    endfunction

    // {alu_src, alu_op} expected in EXEC for each non-branch opcode
    function automatic logic [3:0] alu_of(input logic [5:0] op);
        case (op)
            6'h00: return 4'b0_000;
            6'h01: return 4'b0_001;
            6'h02: return 4'b0_010;
            6'h03: return 4'b0_011;
            6'h04: return 4'b1_100;
            6'h05: return 4'b1_101;
            6'h08: return 4'b1_000;
            6'h09: return 4'b1_001;
            6'h0C: return 4'b0_100;
            6'h0D: return 4'b0_101;
            6'h0E: return 4'b1_110;
            6'h10, 6'h11: return 4'b1_000;
            6'h12: return 4'b0_110;
            default: return 4'b0_000;
        endcase
    endfunction

    function automatic out_t base();
        out_t e = '0;
        e.busy    = 1'b1;
        e.retired = ret_cnt;
        return e;
    endfunction

    task automatic push(input byte ph, input logic [5:0] op, input logic ir, input logic dr,
                        input logic [3:0] fl, input out_t e);
        vec_t v;
        v.ph = ph; v.op = op; v.ir = ir; v.dr = dr; v.fl = fl; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic add_trap(input logic [1:0] cause, input int n);
        out_t e;
        for (int i = 0; i < n; i++) begin
            e = '0;
            e.trap = 1'b1;
            e.trap_cause = cause;
            e.retired = ret_cnt;
            push("T", 6'($urandom), rbit(), rbit(), 4'($urandom), e);
        end
    endtask

    // Expected trace for one instruction; iw/dw = ready-low cycles before ready (> TMO means never)
    task automatic add_instr(input logic [5:0] op, input logic [3:0] fl, input int iw, input int dw);
        out_t e;
        logic [3:0] as;
        bit lw, sw, taken;
        int idx;
        lw = (op == 6'h10);
        sw = (op == 6'h11);
        for (int i = 0; i < iw && i <= TMO; i++) begin
            e = base(); e.imem_req = 1'b1;
            push("F", 6'($urandom), 1'b0, rbit(), fl, e);
        end
        if (iw > TMO) begin add_trap(2'b10, 12); return; end
        e = base(); e.imem_req = 1'b1; e.ir_write = 1'b1;
        push("F", 6'($urandom), 1'b1, rbit(), fl, e);
        e = base();
        push("D", op, rbit(), rbit(), fl, e);
        if (!legal(op)) begin add_trap(2'b01, 20); return; end
        e = base();
        if (op >= 6'h14) begin
            e.pc_write = 1'b1;
            e.push_ret = (op == 6'h1E);
            if (op == 6'h14 || op == 6'h1E) e.pc_src = 2'd1;
            else if (op == 6'h15)           e.pc_src = 2'd2;
            else if (op == 6'h1F)           e.pc_src = 2'd3;
            else begin
                idx   = int'(op) - 16'h16;
                taken = fl[3 - idx / 2] ^ ((idx % 2) != 0);
                e.pc_src = taken ? 2'd1 : 2'd0;
            end
            push("E", op, rbit(), rbit(), fl, e);
            ret_cnt++;
            return;
        end
        as = alu_of(op);
        e.alu_src = as[3];
        e.alu_op  = as[2:0];
        e.flags_we = !(lw || sw);
        push("E", op, rbit(), rbit(), fl, e);
        if (lw || sw) begin
            for (int i = 0; i < dw && i <= TMO; i++) begin
                e = base(); e.dmem_read = lw; e.dmem_write = sw;
                push("M", op, rbit(), 1'b0, fl, e);
            end
            if (dw > TMO) begin add_trap(2'b11, 12); return; end
            e = base(); e.dmem_read = lw; e.dmem_write = sw; e.pc_write = sw;
            push("M", op, rbit(), 1'b1, fl, e);
            if (sw) begin ret_cnt++; return; end
        end
        e = base(); e.reg_write = 1'b1; e.mem_to_reg = lw; e.pc_write = 1'b1;
        push("W", op, rbit(), rbit(), fl, e);
        ret_cnt++;
    endtask

    task automatic run_vectors(input string name);
        for (int i = 0; i < vq.size(); i++) begin
            opcode = vq[i].op;
            imem_ready = vq[i].ir;
            dmem_ready = vq[i].dr;
            {flag_z, flag_c, flag_s, flag_v} = vq[i].fl;
            @(negedge clk);
            check($sformatf("%s[%0d] ph=%c op=%h", name, i, vq[i].ph, vq[i].op), act, vq[i].exp);
            @(posedge clk);
            #1;
        end
        vq.delete();
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        ret_cnt = '0;
        push("I", 6'($urandom), rbit(), rbit(), 4'($urandom), '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0; opcode = '0;
        {flag_z, flag_c, flag_s, flag_v} = 4'h0;
        #2 check("reset_state", act, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        release_reset();
    endtask

    initial begin
        logic [5:0] op;
        int iw, dw;

        // Directed program: plain ALU stream, LW with waits, branch forms, latency boundaries
        do_reset();
        repeat (3) add_instr(6'h00, 4'h0, 0, 0);
        add_instr(6'h10, 4'h0, 0, 3);
        add_instr(6'h16, 4'b1000, 0, 0);
        add_instr(6'h16, 4'b0111, 0, 0);
        add_instr(6'h1E, 4'h0, 0, 0);
        add_instr(6'h1F, 4'h0, 0, 0);
        add_instr(6'h14, 4'h0, 1, 0);
        add_instr(6'h15, 4'h0, 0, 0);
        for (int o = 16'h16; o <= 16'h1D; o++) begin
            add_instr(6'(o), 4'hF, 0, 0);
            add_instr(6'(o), 4'h0, 0, 0);
        end
        for (int o = 0; o <= 16'h12; o++)
            if (legal(6'(o)) && o != 16'h10 && o != 16'h11) add_instr(6'(o), 4'($urandom), 0, 0);
        add_instr(6'h10, 4'h0, TMO, TMO);
        add_instr(6'h11, 4'h0, 0, 0);
        add_instr(6'h11, 4'h0, 2, TMO);
        run_vectors("directed");

        // Random legal instruction stream with random latencies up to the timeout limit
        repeat (80) begin
            do op = 6'($urandom_range(0, 31)); while (!legal(op));
            iw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TMO)) : int'($urandom_range(0, 2));
            dw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TMO)) : int'($urandom_range(0, 2));
            add_instr(op, 4'($urandom), iw, dw);
        end
        run_vectors("random");

        do_reset();
        add_instr(6'h00, 4'h0, 0, 0);
        add_instr(6'h11, 4'h0, 0, TMO + 1);
        run_vectors("sw_timeout");

        do_reset();
        add_instr(6'h00, 4'h0, 0, 0);
        add_instr(6'h06, 4'h0, 0, 0);
        run_vectors("illegal_06");

        do_reset();
        add_instr(6'h02, 4'h0, 0, 0);
        add_instr(6'h00, 4'h0, TMO + 1, 0);
        run_vectors("imem_timeout");

        do_reset();
        do op = 6'($urandom); while (legal(op));
        add_instr(op, 4'h0, 1, 0);
        run_vectors("illegal_rand");

        // Reset dropped while an LW sits in MEM waiting for dmem_ready
        do_reset();
        add_instr(6'h10, 4'h0, 0, 10);
        while (vq.size() > 7) void'(vq.pop_back());
        run_vectors("lw_pre_abort");
        rst_n = 1'b0;
        #1 check("async_reset_mid_mem", act, '0);
        repeat (2) begin
            @(negedge clk);
            check("held_in_reset", act, '0);
        end
        @(posedge clk);
        #1;
        release_reset();
        add_instr(6'h00, 4'h0, 0, 0);
        add_instr(6'h10, 4'h0, 0, 1);
        run_vectors("refetch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
